// File: rtl/count_sequencer.sv
// Sequencer for an external 8-bit enable/clear counter: start/stop/step/clear control, rate-divided run, halt at limit.
// Latency: control edges act on the next C edge; cnt_en and cnt_clr_n are registered (one-cycle pulses).
// Backpressure: none; a held control level yields one event, and lower-priority events in the same cycle are dropped.
//
// Ports:
//   C, Cb                   clock (rising edge), asynchronous active-low reset
//   start, stop, step, clr  level controls, acted on at their rising edge
//   rate_sel                selects DIV0..DIV3 clocks per increment
//   limit                   terminal count; RUN halts into DONE when count_q == limit
//   count_q                 counter Q fed back from the counter
//   cnt_en                  counter enable, one-cycle pulse per increment
//   cnt_clr_n               counter clear, active-low, one cycle on clr and held during reset
//   state, done             FSM state (IDLE/RUN/PAUSE/DONE) and DONE flag
module count_sequencer #(
    parameter int DIV_W = 26,
    parameter int DIV0  = 50000000,
    parameter int DIV1  = 25000000,
    parameter int DIV2  = 12500000,
    parameter int DIV3  = 2
) (
    input  logic       C,
    input  logic       Cb,
    input  logic       start,
    input  logic       stop,
    input  logic       step,
    input  logic       clr,
    input  logic [1:0] rate_sel,
    input  logic [7:0] limit,
    input  logic [7:0] count_q,
    output logic       cnt_en,
    output logic       cnt_clr_n,
    output logic [1:0] state,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_e;

    // Reload values are one less than the period: div_cnt counts N-1 .. 0,
    // and the cycle where it reads 0 issues the increment.
    localparam logic [DIV_W-1:0] RELOAD0 = DIV_W'(DIV0 - 1);
    localparam logic [DIV_W-1:0] RELOAD1 = DIV_W'(DIV1 - 1);
    localparam logic [DIV_W-1:0] RELOAD2 = DIV_W'(DIV2 - 1);
    localparam logic [DIV_W-1:0] RELOAD3 = DIV_W'(DIV3 - 1);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             cnt_en_q, cnt_en_d;
    logic             cnt_clr_n_q, cnt_clr_n_d;

    logic start_prev_q, stop_prev_q, step_prev_q, clr_prev_q;
    logic start_ev, stop_ev, step_ev, clr_ev;
    logic at_limit;
    logic idle_or_pause;
    logic [DIV_W-1:0] reload;

    assign start_ev = start & ~start_prev_q;
    assign stop_ev  = stop  & ~stop_prev_q;
    assign step_ev  = step  & ~step_prev_q;
    assign clr_ev   = clr   & ~clr_prev_q;

    assign at_limit      = (count_q == limit);
    assign idle_or_pause = (state_q == IDLE) || (state_q == PAUSE);

    // rate_sel is sampled only where a reload happens, so a mid-interval
    // change finishes the interval already in flight.
    always_comb begin
        reload = RELOAD0;
        case (rate_sel)
            2'd0: reload = RELOAD0;
            2'd1: reload = RELOAD1;
            2'd2: reload = RELOAD2;
            2'd3: reload = RELOAD3;
            default: reload = RELOAD0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        cnt_en_d    = 1'b0;
        cnt_clr_n_d = 1'b1;

        // Priority clr > stop > start > step; a present higher-priority event
        // consumes the cycle even where it has no effect in the current state.
        if (clr_ev) begin
            // Any tick due this cycle is dropped: cnt_en_d stays 0.
            state_d     = IDLE;
            div_d       = '0;
            cnt_clr_n_d = 1'b0;
        end else if (stop_ev) begin
            // div_cnt is left as is; the next start reloads it anyway.
            if (state_q == RUN) begin
                state_d = PAUSE;
            end
        end else if (start_ev && idle_or_pause) begin
            state_d = RUN;
            div_d   = reload;
        end else if (step_ev && idle_or_pause) begin
            if (!at_limit) begin
                cnt_en_d = 1'b1;
            end
        end else if (state_q == RUN) begin
            if (at_limit) begin
                state_d = DONE;
            end else if (div_q == '0) begin
                cnt_en_d = 1'b1;
                div_d    = reload;
            end else begin
                div_d = div_q - 1'b1;
            end
        end
    end

    always_ff @(posedge C or negedge Cb) begin
        if (!Cb) begin
            state_q      <= IDLE;
            div_q        <= '0;
            cnt_en_q     <= 1'b0;
            cnt_clr_n_q  <= 1'b0;
            start_prev_q <= 1'b0;
            stop_prev_q  <= 1'b0;
            step_prev_q  <= 1'b0;
            clr_prev_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            cnt_en_q     <= cnt_en_d;
            cnt_clr_n_q  <= cnt_clr_n_d;
            start_prev_q <= start;
            stop_prev_q  <= stop;
            step_prev_q  <= step;
            clr_prev_q   <= clr;
        end
    end

    assign cnt_en    = cnt_en_q;
    assign cnt_clr_n = cnt_clr_n_q;
    assign state     = state_q;
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer with a behavioural 8-bit counter in the feedback loop.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge of C.
// Backpressure: none.
module tb_count_sequencer;

    logic       C;
    logic       Cb;
    logic       start, stop, step, clr;
    logic [1:0] rate_sel;
    logic [7:0] limit;
    logic [7:0] count_q;
    logic       cnt_en;
    logic       cnt_clr_n;
    logic [1:0] state;
    logic       done;

    int total;
    int bad;
    int pulses;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_DONE  = 2'b11;

    count_sequencer #(
        .DIV_W (26),
        .DIV0  (4),
        .DIV1  (8),
        .DIV2  (6),
        .DIV3  (2)
    ) dut (
        .C         (C),
        .Cb        (Cb),
        .start     (start),
        .stop      (stop),
        .step      (step),
        .clr       (clr),
        .rate_sel  (rate_sel),
        .limit     (limit),
        .count_q   (count_q),
        .cnt_en    (cnt_en),
        .cnt_clr_n (cnt_clr_n),
        .state     (state),
        .done      (done)
    );

    // The 8-bit counter being sequenced: async active-low clear, count on En.
    always @(posedge C or negedge cnt_clr_n) begin
        if (!cnt_clr_n)
            count_q <= 8'd0;
        else if (cnt_en)
            count_q <= count_q + 8'd1;
    end

    initial C = 1'b0;
    always #5 C = ~C;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    // Raise one control for a single edge, then drop it.
    task automatic pulse(input int which);
        case (which)
            0: start = 1'b1;
            1: stop  = 1'b1;
            2: step  = 1'b1;
            default: clr = 1'b1;
        endcase
        tick();
        start = 1'b0;
        stop  = 1'b0;
        step  = 1'b0;
        clr   = 1'b0;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        Cb       = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        step     = 1'b0;
        clr      = 1'b0;
        rate_sel = 2'd0;
        limit    = 8'd5;

        // Reset values
        #1;
        tick();
        tick();
        chk("rst_state", 32'(state), 32'(S_IDLE));
        chk("rst_cnt_en", 32'(cnt_en), 32'd0);
        chk("rst_clr_n", 32'(cnt_clr_n), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(count_q), 32'd0);
        Cb = 1'b1;
        tick();
        chk("rel_clr_n", 32'(cnt_clr_n), 32'd1);

        // Run to limit=5 at DIV0=4: pulses at edges 4,8,..,20, DONE from edge 22
        pulse(0);
        for (int k = 1; k <= 30; k++) begin
            tick();
            chk("run_en", 32'(cnt_en), 32'((k % 4 == 0) && (k <= 20)));
            chk("run_count", 32'(count_q), (k >= 5) ? ((k - 1) / 4 > 5 ? 32'd5 : 32'((k - 1) / 4)) : 32'd0);
            chk("run_state", 32'(state), (k >= 22) ? 32'(S_DONE) : 32'(S_RUN));
        end
        chk("done_flag", 32'(done), 32'd1);

        // start in DONE is ignored
        pulse(0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("done_hold_state", 32'(state), 32'(S_DONE));
            chk("done_hold_en", 32'(cnt_en), 32'd0);
        end

        // clr: one-cycle clear, back to IDLE
        pulse(3);
        chk("clr_clr_n", 32'(cnt_clr_n), 32'd0);
        chk("clr_state", 32'(state), 32'(S_IDLE));
        chk("clr_count", 32'(count_q), 32'd0);
        chk("clr_done", 32'(done), 32'd0);
        tick();
        chk("clr_release", 32'(cnt_clr_n), 32'd1);
        chk("clr_count2", 32'(count_q), 32'd0);

        // Stop after count reaches 3, then step three times
        limit = 8'd200;
        pulse(0);
        repeat (13) tick();
        chk("pre_stop_count", 32'(count_q), 32'd3);
        pulse(1);
        chk("stop_state", 32'(state), 32'(S_PAUSE));
        chk("stop_en", 32'(cnt_en), 32'd0);
        pulses = 0;
        repeat (6) begin
            tick();
            if (cnt_en) pulses++;
        end
        chk("pause_no_en", 32'(pulses), 32'd0);
        chk("pause_count", 32'(count_q), 32'd3);
        for (int i = 0; i < 3; i++) begin
            pulse(2);
            chk("step_en_hi", 32'(cnt_en), 32'd1);
            tick();
            chk("step_en_lo", 32'(cnt_en), 32'd0);
            chk("step_count", 32'(count_q), 32'(4 + i));
            chk("step_state", 32'(state), 32'(S_PAUSE));
        end

        // Resume: first tick after a full DIV0
        pulse(0);
        chk("resume_state", 32'(state), 32'(S_RUN));
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("resume_en", 32'(cnt_en), 32'(k == 4));
        end
        pulse(3);
        tick();
        chk("clr2_count", 32'(count_q), 32'd0);

        // Held step in IDLE gives one increment
        step   = 1'b1;
        pulses = 0;
        repeat (20) begin
            tick();
            if (cnt_en) pulses++;
        end
        step = 1'b0;
        repeat (2) begin
            tick();
            if (cnt_en) pulses++;
        end
        chk("held_step_pulses", 32'(pulses), 32'd1);
        chk("held_step_count", 32'(count_q), 32'd1);

        // Step at count_q == limit is ignored
        limit  = 8'd1;
        pulses = 0;
        pulse(2);
        if (cnt_en) pulses++;
        repeat (3) begin
            tick();
            if (cnt_en) pulses++;
        end
        chk("lim_step_pulses", 32'(pulses), 32'd0);
        chk("lim_step_count", 32'(count_q), 32'd1);
        chk("lim_step_state", 32'(state), 32'(S_IDLE));

        // clr and stop together in RUN: clr wins
        limit = 8'd200;
        pulse(0);
        repeat (10) tick();
        chk("pre_cs_count", 32'(count_q), 32'd3);
        clr  = 1'b1;
        stop = 1'b1;
        tick();
        clr  = 1'b0;
        stop = 1'b0;
        chk("cs_state", 32'(state), 32'(S_IDLE));
        chk("cs_clr_n", 32'(cnt_clr_n), 32'd0);
        chk("cs_count", 32'(count_q), 32'd0);
        chk("cs_en", 32'(cnt_en), 32'd0);
        tick();
        chk("cs_release", 32'(cnt_clr_n), 32'd1);

        // Rate change 1 -> 3 mid-interval: 8-cycle interval completes, then every 2
        rate_sel = 2'd1;
        pulse(0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("rate1_en", 32'(cnt_en), 32'(k == 8));
        end
        rate_sel = 2'd3;
        for (int k = 11; k <= 20; k++) begin
            tick();
            chk("rate3_en", 32'(cnt_en), 32'((k == 16) || (k == 18) || (k == 20)));
        end
        chk("rate_count", 32'(count_q), 32'd3);

        // Async reset mid-RUN, sampled before any further clock edge
        Cb = 1'b0;
        #2;
        chk("arst_state", 32'(state), 32'(S_IDLE));
        chk("arst_clr_n", 32'(cnt_clr_n), 32'd0);
        chk("arst_en", 32'(cnt_en), 32'd0);
        chk("arst_count", 32'(count_q), 32'd0);
        tick();
        Cb = 1'b1;
        tick();
        chk("arst_release", 32'(cnt_clr_n), 32'd1);
        chk("arst_idle", 32'(state), 32'(S_IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
- Controller for the 8-bit T-flip-flop counter: drives its enable and active-low clear inputs and watches its Q outputs.
- Runs the counter at a switch-selected rate from a rate divider.
- Supports start, stop and single-step, and halts at a programmable terminal count.
- Sits between the board's KEY/SW inputs and the counter; the counter's Q also feeds the HEX decoders.

Parameters:
- DIV_W, 26, width of the rate-divider down-counter.
- DIV0, 50000000, clocks per increment when rate_sel=0. Must be >=2 and <2^DIV_W; the same limits apply to DIV1-DIV3.
- DIV1, 25000000, clocks per increment when rate_sel=1.
- DIV2, 12500000, clocks per increment when rate_sel=2.
- DIV3, 2, clocks per increment when rate_sel=3.

Ports:
- C  input  1  clock, rising edge.
- Cb  input  1  reset, asynchronous, active-low.
- start  input  1  level; acted on at its rising edge.
- stop  input  1  level; acted on at its rising edge.
- step  input  1  level; acted on at its rising edge.
- clr  input  1  level; acted on at its rising edge.
- rate_sel  input  2  selects DIV0..DIV3.
- limit  input  8  terminal count.
- count_q  input  8  counter Q, fed back from the counter.
- cnt_en  output  1  to counter En; registered; one-cycle pulse per increment.
- cnt_clr_n  output  1  to counter Cb; registered; active-low.
- state  output  2  FSM state: IDLE=00, RUN=01, PAUSE=10, DONE=11.
- done  output  1  high exactly when state==DONE.

Behaviour:
- Reset (Cb=0), asynchronous:
  - state=IDLE, cnt_en=0, cnt_clr_n=0 (counter held cleared), div_cnt=0, edge registers=0, done=0.
  - First rising edge of C after Cb goes high: cnt_clr_n=1.
- Edge detect: each control input is registered once; event = in & ~in_prev. A held level gives exactly one event.
- Events are evaluated each cycle with priority clr > stop > start > step. Only the highest-priority event present that cycle is acted on.
- clr (any state):
  - Next cycle: cnt_clr_n=0 for exactly one cycle, state=IDLE, cnt_en=0, div_cnt=0.
  - A tick pending that cycle is discarded.
- start:
  - From IDLE or PAUSE: go to RUN; div_cnt loads DIVsel-1.
  - First increment is issued DIVsel cycles after the start event.
  - Ignored in RUN and DONE; DONE exits only via clr or reset.
- stop: RUN -> PAUSE. div_cnt is frozen, so a later start reloads it. cnt_en=0 from the next cycle.
- step:
  - In IDLE or PAUSE with count_q != limit: cnt_en=1 for one cycle; state unchanged.
  - Ignored in RUN, in DONE, or when count_q==limit.
  - Never enters DONE.
- RUN, each cycle, when no higher-priority event is present:
  - If count_q==limit: state=DONE; no increment is issued and cnt_en is 0 in DONE.
  - Else if div_cnt==0: cnt_en=1 next cycle; div_cnt reloads DIVsel-1.
  - Else: div_cnt decrements.
- Timing:
  - Counter increments on the edge after cnt_en is registered high.
  - count_q is therefore valid one cycle after the cnt_en pulse.
  - DIV>=2 guarantees the limit compare always sees the updated value.
- rate_sel changes mid-RUN take effect at the next reload only.
- limit is compared combinationally each cycle. Changing limit below the current count does not stop RUN until the 8-bit counter wraps (255 -> 0) to limit.
- Wrap: with limit > count, the counter never passes 255 before stopping.
- cnt_en and cnt_clr_n are never active in the same cycle.
- Reset asserted mid-RUN: all state returns to reset values immediately, without waiting for a clock edge.

Test Plan:
- Override DIV0=4; reset, release, limit=5, rate_sel=0, pulse start -> cnt_en pulses every 4 cycles; count_q 0..5; state=DONE and done=1 one cycle after count_q==5; no further cnt_en.
- From DONE, pulse start -> no change. Pulse clr -> cnt_clr_n low for exactly 1 cycle, count_q=0, state=IDLE.
- RUN with limit=200, stop after count_q=3 -> state=PAUSE, count stays 3. Three step pulses -> count_q=6, one cnt_en each. Start -> RUN resumes, first tick after a full DIV0.
- Hold step high for 20 cycles in IDLE -> exactly one increment. Step with count_q==limit -> no cnt_en.
- Assert clr and stop in the same cycle during RUN -> clr wins: state=IDLE, count cleared.
- Override DIV1=8, DIV3=2. Switch rate_sel 1->3 mid-interval -> current 8-cycle interval completes, then pulses every 2 cycles. Drop Cb mid-RUN -> cnt_clr_n=0, state=IDLE immediately, without a clock edge.
